// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single-port-per-direction
// memory. Reads return one cycle after grant; an optional zero-fill sweep runs
// after reset before any request is accepted.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid_0,
  input  logic                  req_valid_1,
  output logic                  req_ready_0,
  output logic                  req_ready_1,
  input  logic                  req_write_0,
  input  logic                  req_write_1,
  input  logic [ADDR_WIDTH-1:0] req_addr_0,
  input  logic [ADDR_WIDTH-1:0] req_addr_1,
  input  logic [DATA_WIDTH-1:0] req_wdata_0,
  input  logic [DATA_WIDTH-1:0] req_wdata_1,
  output logic                  resp_valid_0,
  output logic                  resp_valid_1,
  output logic [DATA_WIDTH-1:0] resp_data_0,
  output logic [DATA_WIDTH-1:0] resp_data_1,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_ctrl,
  input  logic [DATA_WIDTH-1:0] mem_read_out
);

  typedef enum logic {CLEAR, SERVE} state_t;

  localparam logic [ADDR_WIDTH:0] CLR_ONE = 1;

  state_t state, state_nxt;

  // one extra bit so the sweep counter cannot wrap back to 0 unnoticed
  logic [ADDR_WIDTH:0]            clr_addr;
  logic                           clr_last;
  logic                           rr;
  logic [1:0]                     resp_q;     // port that was granted a read last cycle
  logic [ADDR_WIDTH-1:0]          rd_addr_q;  // read address held between grants

  // per-port request fields packed so the granted port can be indexed
  logic [1:0]                     vld, wr, gnt;
  logic [1:0][ADDR_WIDTH-1:0]     addr;
  logic [1:0][DATA_WIDTH-1:0]     wdata;
  logic                           gnt_port;

  assign vld   = {req_valid_1, req_valid_0};
  assign wr    = {req_write_1, req_write_0};
  assign addr  = {req_addr_1, req_addr_0};
  assign wdata = {req_wdata_1, req_wdata_0};

  assign clr_last = (clr_addr[ADDR_WIDTH-1:0] == {ADDR_WIDTH{1'b1}});

  // next state and grant: a single grant per cycle, rr breaks ties
  always_comb begin
    state_nxt = state;
    gnt       = 2'b00;
    gnt_port  = 1'b0;
    case (state)
      CLEAR: if (clr_last) state_nxt = SERVE;
      SERVE: begin
        if (vld[0] && vld[1]) begin
          gnt_port = rr;
          gnt[rr]  = 1'b1;
        end else if (vld[0]) begin
          gnt[0]   = 1'b1;
        end else if (vld[1]) begin
          gnt_port = 1'b1;
          gnt[1]   = 1'b1;
        end
      end
      default: state_nxt = SERVE;
    endcase
    if (!reset_n) gnt = 2'b00;
  end

  // memory drive: sweep writes in CLEAR, granted request in SERVE
  always_comb begin
    mem_write_ctrl = 1'b0;
    mem_write_addr = addr[gnt_port];
    mem_write_data = wdata[gnt_port];
    mem_read_addr  = rd_addr_q;
    if (state == CLEAR) begin
      mem_write_ctrl = reset_n;
      mem_write_addr = clr_addr[ADDR_WIDTH-1:0];
      mem_write_data = '0;
    end else if (|gnt) begin
      if (wr[gnt_port]) mem_write_ctrl = 1'b1;
      else              mem_read_addr  = addr[gnt_port];
    end
  end

  assign req_ready_0  = gnt[0];
  assign req_ready_1  = gnt[1];
  assign resp_valid_0 = resp_q[0] & reset_n;
  assign resp_valid_1 = resp_q[1] & reset_n;
  assign resp_data_0  = mem_read_out;
  assign resp_data_1  = mem_read_out;
  assign busy         = reset_n ? (state == CLEAR) : CLEAR_ON_RESET;

  // state, sweep counter, round-robin pointer and response flags
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= CLEAR_ON_RESET ? CLEAR : SERVE;
      clr_addr  <= '0;
      rr        <= 1'b0;
      resp_q    <= 2'b00;
      rd_addr_q <= '0;
    end else begin
      state     <= state_nxt;
      if (state == CLEAR) clr_addr <= clr_addr + CLR_ONE;
      if (|gnt) rr <= ~gnt_port;
      resp_q    <= gnt & ~wr;
      rd_addr_q <= mem_read_addr;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural registered-read memory.
// A second instance with the sweep disabled checks the no-clear path.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset_n, preload;
  logic        v0, v1, w0, w1, rdy0, rdy1, rv0, rv1, busy, wc;
  logic [3:0]  a0, a1, ra, wa;
  logic [15:0] d0, d1, rd0, rd1, wd, rdo;

  logic        n_v0, n_rdy0, n_rdy1, n_rv0, n_rv1, n_busy, n_wc;
  logic [3:0]  n_a0, n_ra, n_wa;
  logic [15:0] n_rd0, n_rd1, n_wd, n_rdo;

  logic [15:0] mem   [16];
  logic [15:0] n_mem [16];

  int n_tests = 0;
  int n_fail  = 0;
  int cnt;

  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .CLEAR_ON_RESET(1'b1)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid_0(v0), .req_valid_1(v1), .req_ready_0(rdy0), .req_ready_1(rdy1),
    .req_write_0(w0), .req_write_1(w1), .req_addr_0(a0), .req_addr_1(a1),
    .req_wdata_0(d0), .req_wdata_1(d1),
    .resp_valid_0(rv0), .resp_valid_1(rv1), .resp_data_0(rd0), .resp_data_1(rd1),
    .busy(busy), .mem_read_addr(ra), .mem_write_addr(wa), .mem_write_data(wd),
    .mem_write_ctrl(wc), .mem_read_out(rdo)
  );

  mem_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .CLEAR_ON_RESET(1'b0)) dut_nc (
    .clock(clock), .reset_n(reset_n),
    .req_valid_0(n_v0), .req_valid_1(1'b0), .req_ready_0(n_rdy0), .req_ready_1(n_rdy1),
    .req_write_0(1'b0), .req_write_1(1'b0), .req_addr_0(n_a0), .req_addr_1(4'h0),
    .req_wdata_0(16'h0), .req_wdata_1(16'h0),
    .resp_valid_0(n_rv0), .resp_valid_1(n_rv1), .resp_data_0(n_rd0), .resp_data_1(n_rd1),
    .busy(n_busy), .mem_read_addr(n_ra), .mem_write_addr(n_wa), .mem_write_data(n_wd),
    .mem_write_ctrl(n_wc), .mem_read_out(n_rdo)
  );

  // memory models: registered read, write on write_ctrl, bulk preload to 0xFFFF
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) begin
        mem[i]   <= 16'hFFFF;
        n_mem[i] <= 16'hFFFF;
      end
    end else begin
      if (wc)   mem[wa]   <= wd;
      if (n_wc) n_mem[n_wa] <= n_wd;
    end
    rdo   <= mem[ra];
    n_rdo <= n_mem[n_ra];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one-cycle read: grant this cycle, response checked next cycle
  task automatic rd(input bit p, input logic [3:0] a, input logic [15:0] exp, input string tag);
    if (!p) begin v0 = 1'b1; w0 = 1'b0; a0 = a; end
    else    begin v1 = 1'b1; w1 = 1'b0; a1 = a; end
    #1 chk({tag, "_rdy"}, 32'(p ? rdy1 : rdy0), 32'd1);
    @(negedge clock); v0 = 1'b0; v1 = 1'b0;
    #1;
    chk({tag, "_rv"},  32'(p ? rv1 : rv0), 32'd1);
    chk({tag, "_ov"},  32'(p ? rv0 : rv1), 32'd0);
    chk({tag, "_dat"}, 32'(p ? rd1 : rd0), 32'(exp));
  endtask

  // one-cycle write: check grant and memory drive
  task automatic wr(input bit p, input logic [3:0] a, input logic [15:0] dat, input string tag);
    if (!p) begin v0 = 1'b1; w0 = 1'b1; a0 = a; d0 = dat; end
    else    begin v1 = 1'b1; w1 = 1'b1; a1 = a; d1 = dat; end
    #1;
    chk({tag, "_rdy"}, 32'(p ? rdy1 : rdy0), 32'd1);
    chk({tag, "_wc"},  32'(wc), 32'd1);
    chk({tag, "_wa"},  32'(wa), 32'(a));
    chk({tag, "_wd"},  32'(wd), 32'(dat));
    @(negedge clock); v0 = 1'b0; v1 = 1'b0; w0 = 1'b0; w1 = 1'b0;
    #1;
  endtask

  // count busy cycles from the current mid-cycle point, bounded
  task automatic count_busy(input int start, input string tag);
    cnt = start;
    while (busy && cnt < 40) begin
      cnt++;
      @(negedge clock); #1;
    end
    chk(tag, 32'(cnt), 32'd16);
  endtask

  initial begin
    reset_n = 1'b0; preload = 1'b1;
    v0 = 1'b1; v1 = 1'b0; w0 = 1'b0; w1 = 1'b0; a0 = 4'h0; a1 = 4'h0; d0 = '0; d1 = '0;
    n_v0 = 1'b1; n_a0 = 4'h7;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_busy",   32'(busy),   32'd1);
    chk("rst_rdy0",   32'(rdy0),   32'd0);
    chk("rst_rv0",    32'(rv0),    32'd0);
    chk("rst_wc",     32'(wc),     32'd0);
    chk("rst_nbusy",  32'(n_busy), 32'd0);
    chk("rst_nrdy0",  32'(n_rdy0), 32'd0);

    // release reset: sweep starts at address 0, no-clear instance serves at once
    @(negedge clock);
    reset_n = 1'b1; preload = 1'b0;
    #1;
    chk("clr_rdy0",  32'(rdy0),   32'd0);
    chk("clr_wc",    32'(wc),     32'd1);
    chk("clr_wa0",   32'(wa),     32'd0);
    chk("clr_wd",    32'(wd),     32'd0);
    chk("nc_rdy0",   32'(n_rdy0), 32'd1);
    chk("nc_busy",   32'(n_busy), 32'd0);
    @(negedge clock); v0 = 1'b0; n_v0 = 1'b0;
    #1;
    chk("nc_rv0",    32'(n_rv0),  32'd1);
    chk("nc_rd0",    32'(n_rd0),  32'hFFFF);
    count_busy(1, "clr_len");
    chk("nc_busy2",  32'(n_busy), 32'd0);

    for (int i = 0; i < 16; i++) rd(1'b0, 4'(i), 16'h0000, "clr_rd");

    // single port write then read, and cross-port write then read
    wr(1'b0, 4'h5, 16'hBEEF, "sp_wr");
    rd(1'b0, 4'h5, 16'hBEEF, "sp_rd");
    wr(1'b1, 4'h3, 16'h1234, "mx_wr");
    rd(1'b0, 4'h3, 16'h1234, "mx_rd");

    // set up distinct data, leaving rr pointing at port 0
    wr(1'b0, 4'h2, 16'h2222, "pre_wr2");
    wr(1'b1, 4'h1, 16'h1111, "pre_wr1");

    // contention: both ports hold reads, grants alternate 0,1,0,1
    v0 = 1'b1; w0 = 1'b0; a0 = 4'h1;
    v1 = 1'b1; w1 = 1'b0; a1 = 4'h2;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ct_rdy0", 32'(rdy0), 32'((i % 2) == 0));
      chk("ct_rdy1", 32'(rdy1), 32'((i % 2) == 1));
      if (i % 2 == 1) begin
        chk("ct_rv0", 32'(rv0), 32'd1);
        chk("ct_rd0", 32'(rd0), 32'h1111);
        chk("ct_nv1", 32'(rv1), 32'd0);
      end else if (i > 0) begin
        chk("ct_rv1", 32'(rv1), 32'd1);
        chk("ct_rd1", 32'(rd1), 32'h2222);
        chk("ct_nv0", 32'(rv0), 32'd0);
      end
      @(negedge clock);
    end
    v0 = 1'b0; v1 = 1'b0;
    #1;
    chk("ct_rv1e", 32'(rv1), 32'd1);
    chk("ct_rd1e", 32'(rd1), 32'h2222);
    chk("ct_nv0e", 32'(rv0), 32'd0);

    // reset right after a read grant: response suppressed, sweep restarts
    v0 = 1'b1; w0 = 1'b0; a0 = 4'h5;
    #1 chk("rm_rdy0", 32'(rdy0), 32'd1);
    @(negedge clock); v0 = 1'b0; reset_n = 1'b0;
    #1;
    chk("rm_rv0",  32'(rv0),  32'd0);
    chk("rm_busy", 32'(busy), 32'd1);
    chk("rm_wc",   32'(wc),   32'd0);
    @(negedge clock); reset_n = 1'b1;
    #1;
    chk("rm_rv0b", 32'(rv0),  32'd0);
    chk("rm_wa0",  32'(wa),   32'd0);
    chk("rm_wc1",  32'(wc),   32'd1);

    // reset in the middle of the sweep restarts it at address 0
    repeat (5) @(negedge clock);
    #1 chk("mc_wa5", 32'(wa), 32'd5);
    @(negedge clock); reset_n = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    #1;
    chk("mc_wa0", 32'(wa), 32'd0);
    count_busy(0, "mc_len");
    rd(1'b0, 4'h5, 16'h0000, "mc_rd5");
    rd(1'b1, 4'h1, 16'h0000, "mc_rd1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
